// File: rtl/apb_master_arb_if.sv
`default_nettype none
// ============================================================================
// Module      : apb_master_arb_if
// Description : APB bus bundle between the arbitrating master and a slave.
// Revision    : 1.0
// ============================================================================
interface apb_master_arb_if #(
    parameter int PADDR_WIDTH  = 32,
    parameter int PWDATA_WIDTH = 8,
    parameter int PRDATA_WIDTH = PWDATA_WIDTH
);
    logic [PADDR_WIDTH-1:0]  paddr;
    logic                    prwd;
    logic [PWDATA_WIDTH-1:0] pwdata;
    logic                    penable;
    logic [15:0]             psel;
    logic [PRDATA_WIDTH-1:0] prdata;
    logic                    pready;
    logic                    pslverr;

    modport master (
        output paddr, prwd, pwdata, penable, psel,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  paddr, prwd, pwdata, penable, psel,
        output prdata, pready, pslverr
    );
endinterface
`default_nettype wire

// File: rtl/apb_master_arb.sv
`default_nettype none
// ============================================================================
// Module      : apb_master_arb
// Description : Round-robin arbiter driving a single APB master with timeout.
// Revision    : 1.0
// ============================================================================
module apb_master_arb #(
    parameter int PADDR_WIDTH  = 32,
    parameter int PWDATA_WIDTH = 8,
    parameter int PRDATA_WIDTH = PWDATA_WIDTH,
    parameter int NUM_REQ      = 4,
    parameter int TIMEOUT      = 16
) (
    input  wire logic                            pclock,
    input  wire logic                            preset,
    input  wire logic [NUM_REQ-1:0]              req_valid,
    input  wire logic [NUM_REQ-1:0]              req_write,
    input  wire logic [NUM_REQ*PADDR_WIDTH-1:0]  req_addr,
    input  wire logic [NUM_REQ*PWDATA_WIDTH-1:0] req_wdata,
    output logic      [NUM_REQ-1:0]              req_done,
    output logic      [PRDATA_WIDTH-1:0]         rsp_rdata,
    output logic                                 rsp_err,
    apb_master_arb_if.master                     apb
);
    localparam int c_PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2
    } state_t;

    state_t                    r_state;
    state_t                    w_state_nx;
    logic [c_PTR_W-1:0]        r_ptr;
    logic [c_PTR_W-1:0]        r_winner;
    logic [7:0]                r_cnt;
    logic [7:0]                w_cnt_inc;
    logic [NUM_REQ-1:0]        w_req;
    logic                      w_any;
    logic [c_PTR_W-1:0]        w_win;
    logic [c_PTR_W:0]          w_sum;
    logic [c_PTR_W-1:0]        w_cand;
    logic [PADDR_WIDTH-1:0]    w_addr;
    logic [PWDATA_WIDTH-1:0]   w_wdata;
    logic                      w_write;
    logic                      w_complete;
    logic                      w_abort;
    logic [c_PTR_W-1:0]        w_ptr_nx;
    logic [NUM_REQ-1:0]        w_done_vec;

    // A requester whose done pulse is showing this cycle has already been served.
    assign w_req      = req_valid & ~req_done;
    assign w_cnt_inc  = r_cnt + 8'd1;
    assign w_ptr_nx   = (r_winner == c_PTR_W'(NUM_REQ - 1)) ? '0 : r_winner + 1'b1;
    assign w_done_vec = {{(NUM_REQ-1){1'b0}}, 1'b1} << r_winner;

    // Scan from the highest offset down so the nearest requester after r_ptr wins.
    always_comb begin
        w_any  = 1'b0;
        w_win  = '0;
        w_sum  = '0;
        w_cand = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_sum = {1'b0, r_ptr} + (c_PTR_W + 1)'(k);
            if (w_sum >= (c_PTR_W + 1)'(NUM_REQ)) begin
                w_sum = w_sum - (c_PTR_W + 1)'(NUM_REQ);
            end
            w_cand = w_sum[c_PTR_W-1:0];
            if (w_req[w_cand]) begin
                w_any = 1'b1;
                w_win = w_cand;
            end
        end
    end

    always_comb begin
        w_addr  = '0;
        w_wdata = '0;
        w_write = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_win == c_PTR_W'(i)) begin
                w_addr  = req_addr[i*PADDR_WIDTH +: PADDR_WIDTH];
                w_wdata = req_wdata[i*PWDATA_WIDTH +: PWDATA_WIDTH];
                w_write = req_write[i];
            end
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_complete = 1'b0;
        w_abort    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_any) w_state_nx = S_SETUP;
            end
            S_SETUP: begin
                w_state_nx = S_ACCESS;
            end
            S_ACCESS: begin
                // pready wins over the timeout when both land in the same cycle.
                if (apb.pready) begin
                    w_complete = 1'b1;
                    w_state_nx = S_IDLE;
                end else if (w_cnt_inc == 8'(TIMEOUT)) begin
                    w_abort    = 1'b1;
                    w_state_nx = S_IDLE;
                end
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge pclock or negedge preset) begin
        if (!preset) r_state <= S_IDLE;
        else         r_state <= w_state_nx;
    end

    always_ff @(posedge pclock or negedge preset) begin
        if (!preset) begin
            apb.paddr   <= '0;
            apb.prwd    <= 1'b0;
            apb.pwdata  <= '0;
            apb.penable <= 1'b0;
            apb.psel    <= '0;
            req_done    <= '0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            r_ptr       <= '0;
            r_winner    <= '0;
            r_cnt       <= '0;
        end else begin
            req_done <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_winner   <= w_win;
                        apb.paddr  <= w_addr;
                        apb.prwd   <= w_write;
                        apb.pwdata <= w_wdata;
                        apb.psel   <= 16'h0001 << w_addr[PADDR_WIDTH-1 -: 4];
                    end
                end
                S_SETUP: begin
                    apb.penable <= 1'b1;
                    r_cnt       <= '0;
                end
                S_ACCESS: begin
                    if (w_complete || w_abort) begin
                        req_done    <= w_done_vec;
                        apb.psel    <= '0;
                        apb.penable <= 1'b0;
                        r_ptr       <= w_ptr_nx;
                    end
                    if (w_complete) begin
                        rsp_err <= apb.pslverr;
                        if (!apb.prwd) rsp_rdata <= apb.prdata;
                    end else if (w_abort) begin
                        rsp_err   <= 1'b1;
                        rsp_rdata <= '0;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_apb_master_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_apb_master_arb
// Description : Directed plus randomized bench for apb_master_arb with a
//               transaction-level reference model.
// Revision    : 1.0
// ============================================================================
module tb_apb_master_arb;
    localparam int TIMEOUT = 16;
    localparam int NREQ    = 4;

    logic          pclock = 1'b0;
    logic          preset;
    logic [3:0]    req_valid;
    logic [3:0]    req_write;
    logic [127:0]  req_addr;
    logic [31:0]   req_wdata;
    logic [3:0]    req_done;
    logic [7:0]    rsp_rdata;
    logic          rsp_err;

    int n_checks = 0;
    int n_err    = 0;

    // Reference model state: rotation pointer, last read data, requester masked by its done pulse.
    int         m_ptr   = 0;
    logic [7:0] m_rdata = 8'h00;
    int         m_prev  = -1;

    apb_master_arb_if #(.PADDR_WIDTH(32), .PWDATA_WIDTH(8), .PRDATA_WIDTH(8)) apb ();

    apb_master_arb #(
        .PADDR_WIDTH(32), .PWDATA_WIDTH(8), .PRDATA_WIDTH(8),
        .NUM_REQ(NREQ), .TIMEOUT(TIMEOUT)
    ) dut (
        .pclock   (pclock),
        .preset   (preset),
        .req_valid(req_valid),
        .req_write(req_write),
        .req_addr (req_addr),
        .req_wdata(req_wdata),
        .req_done (req_done),
        .rsp_rdata(rsp_rdata),
        .rsp_err  (rsp_err),
        .apb      (apb)
    );

    always #5 pclock = ~pclock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input bit wr, input logic [31:0] a, input logic [7:0] d);
        req_write[i]          = wr;
        req_addr[i*32 +: 32]  = a;
        req_wdata[i*8 +: 8]   = d;
        req_valid[i]          = 1'b1;
    endtask

    task automatic idle(input int n);
        for (int c = 0; c < n; c++) begin
            @(negedge pclock);
            chk("idle_psel", apb.psel, 32'h0);
            chk("idle_penable", apb.penable, 32'h0);
        end
        m_prev = -1;
    endtask

    // Called at a negedge where the DUT sits in IDLE; returns at the negedge of the done cycle.
    task automatic run_xfer(input int waits, input bit serr, input logic [7:0] rd,
                            input bit drop_early, input bit keep_valid, input bit add_new);
        int          win;
        int          idx;
        int          acc;
        bit          tmo;
        logic [31:0] a;
        logic        wr;
        logic [7:0]  d;
        logic [15:0] ps;
        logic [7:0]  exp_rd;
        win = -1;
        for (int k = 0; k < NREQ; k++) begin
            idx = (m_ptr + k) % NREQ;
            if (win < 0 && req_valid[idx] && idx != m_prev) win = idx;
        end
        if (win < 0) win = 0;
        a   = req_addr[win*32 +: 32];
        wr  = req_write[win];
        d   = req_wdata[win*8 +: 8];
        ps  = 16'h0001 << a[31:28];
        acc = (waits < TIMEOUT) ? waits + 1 : TIMEOUT;
        tmo = (waits >= TIMEOUT);

        @(negedge pclock);
        chk("setup_psel", apb.psel, 32'(ps));
        chk("setup_penable", apb.penable, 32'h0);
        chk("setup_paddr", apb.paddr, a);
        chk("setup_prwd", apb.prwd, 32'(wr));
        chk("setup_pwdata", apb.pwdata, 32'(d));
        chk("setup_done", req_done, 32'h0);
        apb.pready = 1'b0;
        if (drop_early) req_valid[win] = 1'b0;

        for (int c = 0; c < acc; c++) begin
            @(negedge pclock);
            chk("acc_penable", apb.penable, 32'h1);
            chk("acc_psel", apb.psel, 32'(ps));
            chk("acc_paddr", apb.paddr, a);
            chk("acc_done", req_done, 32'h0);
            apb.pready  = (c == waits);
            apb.pslverr = (c == waits) ? serr : 1'($urandom_range(0, 1));
            apb.prdata  = (c == waits) ? rd : 8'($urandom);
            if (add_new && c == 0) begin
                for (int i = 0; i < NREQ; i++) begin
                    if (!req_valid[i] && $urandom_range(0, 2) == 0)
                        set_req(i, 1'($urandom_range(0, 1)), $urandom, 8'($urandom));
                end
            end
        end

        @(negedge pclock);
        apb.pready  = 1'b0;
        apb.pslverr = 1'b0;
        exp_rd = tmo ? 8'h00 : (wr ? m_rdata : rd);
        chk("done_vec", req_done, 32'(4'b0001 << win));
        chk("done_psel", apb.psel, 32'h0);
        chk("done_penable", apb.penable, 32'h0);
        chk("done_err", rsp_err, tmo ? 32'h1 : 32'(serr));
        chk("done_rdata", rsp_rdata, 32'(exp_rd));
        m_rdata = exp_rd;
        m_ptr   = (win + 1) % NREQ;
        m_prev  = win;
        if (!keep_valid) req_valid[win] = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        preset      = 1'b1;
        req_valid   = '0;
        req_write   = '0;
        req_addr    = '0;
        req_wdata   = '0;
        apb.pready  = 1'b0;
        apb.pslverr = 1'b0;
        apb.prdata  = '0;
        #1 preset = 1'b0;
        #1;
        chk("rst_psel", apb.psel, 32'h0);
        chk("rst_penable", apb.penable, 32'h0);
        chk("rst_prwd", apb.prwd, 32'h0);
        chk("rst_paddr", apb.paddr, 32'h0);
        chk("rst_pwdata", apb.pwdata, 32'h0);
        chk("rst_done", req_done, 32'h0);
        chk("rst_err", rsp_err, 32'h0);
        chk("rst_rdata", rsp_rdata, 32'h0);
        repeat (2) @(negedge pclock);

        // Single write from requester 0, immediate pready, psel bit 3.
        set_req(0, 1'b1, 32'h3000_0010, 8'hA5);
        preset = 1'b1;
        run_xfer(0, 1'b0, 8'hEE, 1'b0, 1'b0, 1'b0);

        // Read from requester 2 with three wait cycles.
        set_req(2, 1'b0, 32'h5000_0004, 8'h11);
        run_xfer(3, 1'b0, 8'h5C, 1'b0, 1'b0, 1'b0);

        // Write with slave error, then a normal read after requester drops valid early.
        set_req(3, 1'b1, 32'hA000_0100, 8'h3C);
        run_xfer(0, 1'b1, 8'h99, 1'b0, 1'b0, 1'b0);
        set_req(1, 1'b0, 32'h7000_0020, 8'h00);
        run_xfer(1, 1'b0, 8'h3D, 1'b1, 1'b0, 1'b0);

        // Timeout, exact-timeout boundary, and pready on the last allowed cycle.
        set_req(0, 1'b0, 32'hF000_0000, 8'h00);
        run_xfer(TIMEOUT + 5, 1'b0, 8'h42, 1'b0, 1'b0, 1'b0);
        set_req(1, 1'b0, 32'h2000_0008, 8'h00);
        run_xfer(TIMEOUT, 1'b0, 8'h43, 1'b0, 1'b0, 1'b0);
        set_req(2, 1'b0, 32'hC000_000C, 8'h00);
        run_xfer(TIMEOUT - 1, 1'b1, 8'h77, 1'b0, 1'b0, 1'b0);
        idle(2);

        // Reset asserted in the middle of an ACCESS phase.
        set_req(1, 1'b1, 32'h4000_0040, 8'h5A);
        set_req(2, 1'b0, 32'h6000_0060, 8'h00);
        repeat (3) @(negedge pclock);
        chk("pre_rst_penable", apb.penable, 32'h1);
        #2 preset = 1'b0;
        #1;
        chk("mid_rst_psel", apb.psel, 32'h0);
        chk("mid_rst_penable", apb.penable, 32'h0);
        chk("mid_rst_paddr", apb.paddr, 32'h0);
        chk("mid_rst_prwd", apb.prwd, 32'h0);
        chk("mid_rst_pwdata", apb.pwdata, 32'h0);
        chk("mid_rst_done", req_done, 32'h0);
        chk("mid_rst_err", rsp_err, 32'h0);
        chk("mid_rst_rdata", rsp_rdata, 32'h0);
        @(negedge pclock);
        chk("in_rst_done", req_done, 32'h0);
        m_ptr   = 0;
        m_rdata = 8'h00;
        m_prev  = -1;

        // All four requesters held valid: rotation 0,1,2,3,0.
        for (int i = 0; i < NREQ; i++)
            set_req(i, 1'($urandom_range(0, 1)), $urandom, 8'($urandom));
        preset = 1'b1;
        for (int n = 0; n < 5; n++)
            run_xfer(int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 8'($urandom),
                     1'b0, 1'b1, 1'b0);
        req_valid = '0;

        // Randomized traffic with requests arriving mid-transfer.
        for (int n = 0; n < 40; n++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!req_valid[i] && $urandom_range(0, 2) == 0)
                    set_req(i, 1'($urandom_range(0, 1)), $urandom, 8'($urandom));
            end
            if (req_valid == 4'b0000)
                set_req(int'($urandom_range(0, NREQ - 1)), 1'($urandom_range(0, 1)),
                        $urandom, 8'($urandom));
            w = ($urandom_range(0, 9) == 0) ? int'($urandom_range(TIMEOUT - 2, TIMEOUT + 2))
                                            : int'($urandom_range(0, 4));
            run_xfer(w, 1'($urandom_range(0, 3) == 0), 8'($urandom),
                     1'($urandom_range(0, 4) == 0), 1'b0, 1'($urandom_range(0, 1)));
        end
        req_valid = '0;
        idle(3);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/apb_master_arb.md
APB_MASTER_ARB -- requirements
Module: apb_master_arb

Interface
REQ-001 Parameter PADDR_WIDTH, default 32: APB address width.
REQ-002 Parameter PWDATA_WIDTH, default 8: write-data width.
REQ-003 Parameter PRDATA_WIDTH, default PWDATA_WIDTH: read-data width.
REQ-004 Parameter NUM_REQ, default 4: number of requesters, legal range 2..8.
REQ-005 Parameter TIMEOUT, default 16: maximum ACCESS-phase wait cycles, legal range 2..255.
REQ-006 pclock  in  1: APB clock; single clock domain; all state changes on the rising edge.
REQ-007 preset  in  1: reset, asynchronous assert, active-low.
REQ-008 req_valid  in  NUM_REQ: per-requester transfer request; held until that requester's done pulse.
REQ-009 req_write  in  NUM_REQ: per-requester direction, 1=write.
REQ-010 req_addr  in  NUM_REQ*PADDR_WIDTH: packed addresses; requester i at slice i.
REQ-011 req_wdata  in  NUM_REQ*PWDATA_WIDTH: packed write data.
REQ-012 req_done  out  NUM_REQ: one-cycle completion pulse to the served requester.
REQ-013 rsp_rdata  out  PRDATA_WIDTH: read data; valid in the req_done cycle.
REQ-014 rsp_err  out  1: error flag; valid in the req_done cycle.
REQ-015 paddr  out  PADDR_WIDTH, prwd  out  1, pwdata  out  PWDATA_WIDTH, penable  out  1, psel  out  16: APB master outputs.
REQ-016 prdata  in  PRDATA_WIDTH, pready  in  1, pslverr  in  1: APB slave response.

Function
REQ-017 FSM states IDLE, SETUP, ACCESS; all APB outputs registered.
REQ-018 IDLE: with any req_valid set, select a winner round-robin starting at index ptr; load paddr/prwd/pwdata from the winner; assert the one-hot psel bit; go to SETUP.
REQ-019 psel one-hot bit index = paddr[PADDR_WIDTH-1 -: 4].
REQ-020 SETUP lasts exactly one cycle with penable=0; then ACCESS with penable=1.
REQ-021 ACCESS: paddr, prwd, pwdata and psel held stable until completion.
REQ-022 ACCESS completion occurs when pready=1: sample prdata into rsp_rdata; rsp_err=pslverr; pulse req_done[winner] the following cycle; drop psel and penable; return to IDLE.
REQ-023 ACCESS wait counter starts at 0 on ACCESS entry; increments each cycle pready=0.
REQ-024 When the counter reaches TIMEOUT, the transfer aborts: rsp_err=1, rsp_rdata=0, req_done pulse, return to IDLE.
REQ-025 pready=1 in the same cycle the counter reaches TIMEOUT counts as normal completion.
REQ-026 After each completion or timeout, ptr = winner+1, wrapping from NUM_REQ-1 to 0.
REQ-027 Minimum transfer is SETUP+ACCESS = 2 cycles; no back-to-back SETUP; at least one IDLE cycle between transfers.
REQ-028 A requester dropping req_valid after grant does not abort the transfer.
REQ-029 New requests arriving during a transfer wait; they are arbitrated in the next IDLE.
REQ-030 rsp_rdata holds its last value outside req_done cycles.
REQ-031 prdata is ignored for writes; rsp_rdata is unchanged on write completion.

Reset
REQ-032 preset=0 immediately forces: state IDLE; psel=0; penable=0; prwd=0; paddr=0; pwdata=0; req_done=0; rsp_err=0; rsp_rdata=0; ptr=0; counter=0.
REQ-033 Reset during SETUP or ACCESS abandons the transfer with no req_done pulse; the requester re-issues.

Verification
REQ-034 Single write, req 0, addr 0x3000_0010, data 0xA5, pready=1 immediately -> psel=0x0008; SETUP 1 cycle; ACCESS 1 cycle; req_done[0] pulses; rsp_err=0.
REQ-035 Read from req 2 with pready low 3 cycles, prdata=0x5C -> ACCESS lasts 4 cycles; rsp_rdata=0x5C in the done cycle.
REQ-036 All 4 requesters valid continuously -> grants in order 0,1,2,3,0; each transfer is followed by an IDLE cycle.
REQ-037 pready held 0 with TIMEOUT=16 -> abort after 16 ACCESS wait cycles; rsp_err=1; rsp_rdata=0; ptr advances.
REQ-038 pslverr=1 with pready=1 on a write -> rsp_err=1; the next transfer starts normally.
REQ-039 preset asserted mid-ACCESS -> all outputs go to 0 asynchronously; no req_done; first grant after reset goes to req 0.
